// File: rtl/run_detect_pkg.sv
// Shared types, default sizing and helpers for the run_detect_ctrl block.
// State encodings are plain constants so older tools and checkers can bind to them.
package run_detect_pkg;

   localparam int LEN_W_DEF   = 4;
   localparam int WIN_W_DEF   = 8;
   localparam int WIN_MAX_DEF = 200;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_RUN    = 2'd1;
   localparam logic [1:0] ST_REPORT = 2'd2;

   typedef enum logic [1:0] {
      IDLE   = ST_IDLE,
      RUN    = ST_RUN,
      REPORT = ST_REPORT
   } state_e;

   // A requested length of zero is treated as a run of one bit.
   function automatic logic [31:0] clamp_len(input logic [31:0] len);
      return (len == 32'd0) ? 32'd1 : len;
   endfunction

endpackage

// File: rtl/run_sat_counter.sv
// Saturating up-counter with synchronous clear and asynchronous active-high reset.
module run_sat_counter #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] count
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && !(&count)) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/run_detect_ctrl.sv
// Armed, windowed consecutive-ones run detector with a valid/ready result port.
// Optional hit statistics counter is enabled by defining RUN_STATS_EN.
//
// Response handshake: rsp_valid rises on entry to REPORT and the result fields stay
// frozen until a cycle with rsp_valid && rsp_ready (the transfer); abort drops it.
module run_detect_ctrl
   import run_detect_pkg::*;
#(
   parameter int LEN_W   = LEN_W_DEF,
   parameter int WIN_W   = WIN_W_DEF,
   parameter int WIN_MAX = WIN_MAX_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             x,
   input  logic             start,
   input  logic [LEN_W-1:0] cfg_len,
   input  logic             abort,
   input  logic             rsp_ready,
   output logic             busy,
   output logic             rsp_valid,
   output logic             rsp_hit,
   output logic [WIN_W-1:0] rsp_pos,
   output logic             detect,
`ifdef RUN_STATS_EN
   output logic [15:0]      hit_count,
`endif
   output logic [1:0]       dbg_state
);

   localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_MAX - 1);

   logic [1:0]       state_q;
   logic [LEN_W-1:0] len_q;
   logic [LEN_W-1:0] run_cnt;
   logic [LEN_W-1:0] run_nx;
   logic [WIN_W-1:0] win_cnt;
   logic             in_idle;
   logic             in_run;
   logic             in_report;
   logic             accept;
   logic             hit;
   logic             timeout;
   logic             xfer;

   assign in_idle   = (state_q == ST_IDLE);
   assign in_run    = (state_q == ST_RUN);
   assign in_report = (state_q == ST_REPORT);
   assign dbg_state = state_q;

   // abort also suppresses a start presented in IDLE
   assign accept  = in_idle && start && !abort;
   assign run_nx  = x ? ((&run_cnt) ? run_cnt : run_cnt + 1'b1) : '0;
   assign hit     = in_run && x && (run_nx >= len_q);
   assign timeout = in_run && (win_cnt == WIN_LAST);
   assign xfer    = in_report && rsp_ready && !abort;

   run_sat_counter #(.W(LEN_W)) u_run_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (accept || (in_run && !x)),
      .inc   (in_run && x),
      .count (run_cnt)
   );

`ifdef RUN_STATS_EN
   run_sat_counter #(.W(16)) u_hit_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (1'b0),
      .inc   (xfer && rsp_hit),
      .count (hit_count)
   );
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         len_q     <= '0;
         win_cnt   <= '0;
         busy      <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_hit   <= 1'b0;
         rsp_pos   <= '0;
         detect    <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  state_q <= ST_RUN;
                  busy    <= 1'b1;
                  len_q   <= LEN_W'(clamp_len(32'(cfg_len)));
                  win_cnt <= '0;
               end
            end
            ST_RUN: begin
               if (abort) begin
                  state_q <= ST_IDLE;
                  busy    <= 1'b0;
               end else if (hit) begin
                  // a hit on the last window cycle still reports as a hit
                  state_q   <= ST_REPORT;
                  rsp_valid <= 1'b1;
                  rsp_hit   <= 1'b1;
                  rsp_pos   <= win_cnt;
                  detect    <= 1'b1;
               end else if (timeout) begin
                  state_q   <= ST_REPORT;
                  rsp_valid <= 1'b1;
                  rsp_hit   <= 1'b0;
                  rsp_pos   <= WIN_LAST;
               end else begin
                  win_cnt <= win_cnt + 1'b1;
               end
            end
            ST_REPORT: begin
               detect <= 1'b0;
               if (abort || rsp_ready) begin
                  state_q   <= ST_IDLE;
                  busy      <= 1'b0;
                  rsp_valid <= 1'b0;
                  rsp_hit   <= 1'b0;
                  rsp_pos   <= '0;
               end
            end
            default: begin
               state_q   <= ST_IDLE;
               busy      <= 1'b0;
               rsp_valid <= 1'b0;
               rsp_hit   <= 1'b0;
               rsp_pos   <= '0;
               detect    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_run_detect_ctrl.sv
// Randomized and directed bench for run_detect_ctrl against a bit-list reference model.
// Build with RUN_STATS_EN defined to also cover the hit_count port.
module tb_run_detect_ctrl;

   localparam int LEN_W   = 4;
   localparam int WIN_W   = 8;
   localparam int WIN_MAX = 200;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             x = 1'b0;
   logic             start = 1'b0;
   logic [LEN_W-1:0] cfg_len = '0;
   logic             abort = 1'b0;
   logic             rsp_ready = 1'b0;
   logic             busy;
   logic             rsp_valid;
   logic             rsp_hit;
   logic [WIN_W-1:0] rsp_pos;
   logic             detect;
   logic [1:0]       dbg_state;
`ifdef RUN_STATS_EN
   logic [15:0]      hit_count;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   int exp_hits = 0;
   bit xs[WIN_MAX];

   run_detect_ctrl #(.LEN_W(LEN_W), .WIN_W(WIN_W), .WIN_MAX(WIN_MAX)) dut (
      .clk       (clk),
      .reset     (reset),
      .x         (x),
      .start     (start),
      .cfg_len   (cfg_len),
      .abort     (abort),
      .rsp_ready (rsp_ready),
      .busy      (busy),
      .rsp_valid (rsp_valid),
      .rsp_hit   (rsp_hit),
      .rsp_pos   (rsp_pos),
      .detect    (detect),
`ifdef RUN_STATS_EN
      .hit_count (hit_count),
`endif
      .dbg_state (dbg_state)
   );

   always #5 clk = ~clk;

   // Reference: walk the bit list, first index where the current run of ones reaches the length.
   task automatic model(input int len, output bit h, output int pos);
      int run;
      int l;
      run = 0;
      l   = (len == 0) ? 1 : len;
      h   = 1'b0;
      pos = WIN_MAX - 1;
      for (int k = 0; k < WIN_MAX; k++) begin
         run = xs[k] ? run + 1 : 0;
         if (run >= l) begin
            h   = 1'b1;
            pos = k;
            break;
         end
      end
   endtask

   task automatic fill_zero();
      for (int k = 0; k < WIN_MAX; k++) xs[k] = 1'b0;
   endtask

   // Arms one window, streams xs[], then holds the response for rdy_delay cycles before accepting.
   task automatic run_trial(input string name, input int len, input int rdy_delay,
                            input bit poke_start, input bit start_on_xfer);
      bit exp_hit;
      int exp_pos;
      int seen;
      model(len, exp_hit, exp_pos);
      seen = -1;
      @(negedge clk);
      start   = 1'b1;
      cfg_len = LEN_W'(len);
      for (int i = 0; i <= WIN_MAX + 3; i++) begin
         @(negedge clk);
         if (i > 0 && rsp_valid) begin
            seen = i;
            break;
         end
         start = 1'b0;
         x = (i < WIN_MAX) ? xs[i] : 1'b0;
      end
      x = 1'b0;
      n_checks++;
      if (seen < 0) begin
         n_fail++;
         $display("FAIL %s timeout: rsp_valid never rose, expected at index %0d", name, exp_pos + 1);
         abort = 1'b1;
         @(negedge clk);
         abort = 1'b0;
         return;
      end
      n_checks++;
      if (seen !== exp_pos + 1) begin
         n_fail++;
         $display("FAIL %s latency: valid at index %0d, expected %0d", name, seen, exp_pos + 1);
      end
      n_checks++;
      if (rsp_hit !== exp_hit || rsp_pos !== WIN_W'(exp_pos)) begin
         n_fail++;
         $display("FAIL %s result: hit=%0b pos=%0d, expected hit=%0b pos=%0d",
                  name, rsp_hit, rsp_pos, exp_hit, exp_pos);
      end
      n_checks++;
      if (detect !== exp_hit || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL %s first_report: detect=%0b busy=%0b, expected detect=%0b busy=1",
                  name, detect, busy, exp_hit);
      end
      for (int d = 0; d < rdy_delay; d++) begin
         rsp_ready = 1'b0;
         start     = poke_start;
         @(negedge clk);
         n_checks++;
         if (rsp_valid !== 1'b1 || rsp_hit !== exp_hit || rsp_pos !== WIN_W'(exp_pos) ||
             detect !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL %s hold%0d: valid=%0b hit=%0b pos=%0d detect=%0b busy=%0b, expected 1/%0b/%0d/0/1",
                     name, d, rsp_valid, rsp_hit, rsp_pos, detect, busy, exp_hit, exp_pos);
         end
      end
      rsp_ready = 1'b1;
      start     = start_on_xfer;
      @(negedge clk);
      rsp_ready = 1'b0;
      start     = 1'b0;
      if (exp_hit) exp_hits++;
      n_checks++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0 || detect !== 1'b0) begin
         n_fail++;
         $display("FAIL %s after_xfer: valid=%0b busy=%0b detect=%0b, expected 0/0/0",
                  name, rsp_valid, busy, detect);
      end
      if (start_on_xfer) begin
         @(negedge clk);
         n_checks++;
         if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s xfer_start_ignored: busy=%0b valid=%0b, expected 0/0",
                     name, busy, rsp_valid);
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || rsp_valid !== 1'b0 || rsp_hit !== 1'b0 || rsp_pos !== '0 || detect !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_values: busy=%0b valid=%0b hit=%0b pos=%0d detect=%0b, expected all 0",
                  busy, rsp_valid, rsp_hit, rsp_pos, detect);
      end
`ifdef RUN_STATS_EN
      n_checks++;
      if (hit_count !== 16'd0) begin
         n_fail++;
         $display("FAIL reset_hit_count: got %0d, expected 0", hit_count);
      end
`endif
      reset = 1'b0;
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_after_reset: busy=%0b valid=%0b, expected 0/0", busy, rsp_valid);
      end
   endtask

   task automatic test_directed();
      fill_zero();
      for (int k = 0; k < 4; k++) xs[k] = 1'b1;
      run_trial("run4_pos3", 4, 0, 1'b0, 1'b0);
      fill_zero();
      xs[0] = 1'b1; xs[1] = 1'b1; xs[3] = 1'b1; xs[4] = 1'b1; xs[5] = 1'b1; xs[6] = 1'b1;
      run_trial("run4_broken_pos6", 4, 1, 1'b0, 1'b0);
      fill_zero();
      run_trial("all_zero_miss", 4, 0, 1'b0, 1'b0);
      fill_zero();
      xs[0] = 1'b1;
      run_trial("len0_pos0", 0, 0, 1'b0, 1'b0);
      fill_zero();
      for (int k = WIN_MAX - 15; k < WIN_MAX; k++) xs[k] = 1'b1;
      run_trial("hit_at_last_index", 15, 0, 1'b0, 1'b0);
      fill_zero();
      for (int k = WIN_MAX - 14; k < WIN_MAX; k++) xs[k] = 1'b1;
      run_trial("run_short_at_end_miss", 15, 0, 1'b0, 1'b0);
   endtask

   task automatic test_hold_ready();
      fill_zero();
      for (int k = 2; k < 7; k++) xs[k] = 1'b1;
      run_trial("hold5_start_poke", 5, 5, 1'b1, 1'b0);
   endtask

   task automatic test_back_to_back();
      fill_zero();
      xs[0] = 1'b1; xs[1] = 1'b1;
      run_trial("start_on_xfer", 2, 2, 1'b0, 1'b1);
      run_trial("rearm_after_idle", 2, 0, 1'b0, 1'b0);
   endtask

   task automatic test_random();
      int p;
      int len;
      for (int t = 0; t < 24; t++) begin
         p   = $urandom_range(40, 95);
         len = $urandom_range(0, 15);
         for (int k = 0; k < WIN_MAX; k++) xs[k] = ($urandom_range(0, 99) < p);
         run_trial($sformatf("rand%0d", t), len, $urandom_range(0, 3), $urandom_range(0, 1), 1'b0);
      end
   endtask

   task automatic test_abort();
      // abort arriving with the completing bit wins over the hit
      @(negedge clk); start = 1'b1; cfg_len = 4'd3;
      @(negedge clk); start = 1'b0; x = 1'b1;
      @(negedge clk); x = 1'b1;
      @(negedge clk); x = 1'b1; abort = 1'b1;
      @(negedge clk); x = 1'b0; abort = 1'b0;
      n_checks++;
      if (busy !== 1'b0 || rsp_valid !== 1'b0 || detect !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_run: busy=%0b valid=%0b detect=%0b, expected 0/0/0", busy, rsp_valid, detect);
      end
      @(negedge clk);
      n_checks++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_run_stays_idle: valid=%0b busy=%0b, expected 0/0", rsp_valid, busy);
      end
      // abort in REPORT beats rsp_ready and drops the response
      @(negedge clk); start = 1'b1; cfg_len = 4'd1;
      @(negedge clk); start = 1'b0; x = 1'b1;
      @(negedge clk); x = 1'b0;
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_hit !== 1'b1 || rsp_pos !== 8'd0) begin
         n_fail++;
         $display("FAIL abort_report_setup: valid=%0b hit=%0b pos=%0d, expected 1/1/0", rsp_valid, rsp_hit, rsp_pos);
      end
      abort = 1'b1; rsp_ready = 1'b1;
      @(negedge clk); abort = 1'b0; rsp_ready = 1'b0;
      n_checks++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0 || detect !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_report: valid=%0b busy=%0b detect=%0b, expected 0/0/0", rsp_valid, busy, detect);
      end
      // abort beats start in IDLE
      start = 1'b1; abort = 1'b1;
      @(negedge clk); start = 1'b0; abort = 1'b0;
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_beats_start: busy=%0b, expected 0", busy);
      end
   endtask

   task automatic test_reset_mid_op();
      @(negedge clk); start = 1'b1; cfg_len = 4'd8;
      @(negedge clk); start = 1'b0; x = 1'b1;
      @(negedge clk); x = 1'b1;
      #2 reset = 1'b1;
      #1;
      n_checks++;
      if (busy !== 1'b0 || rsp_valid !== 1'b0 || detect !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid_run: busy=%0b valid=%0b detect=%0b, expected 0/0/0", busy, rsp_valid, detect);
      end
      @(negedge clk); reset = 1'b0; x = 1'b0;
      exp_hits = 0;
      @(negedge clk); start = 1'b1; cfg_len = 4'd2;
      @(negedge clk); start = 1'b0; x = 1'b1;
      @(negedge clk); x = 1'b1;
      @(negedge clk); x = 1'b0;
      #2 reset = 1'b1;
      #1;
      n_checks++;
      if (busy !== 1'b0 || rsp_valid !== 1'b0 || rsp_hit !== 1'b0 || rsp_pos !== '0 || detect !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid_report: busy=%0b valid=%0b hit=%0b pos=%0d detect=%0b, expected all 0",
                  busy, rsp_valid, rsp_hit, rsp_pos, detect);
      end
      @(negedge clk); reset = 1'b0;
      @(negedge clk);
      n_checks++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL no_rsp_after_reset: valid=%0b busy=%0b, expected 0/0", rsp_valid, busy);
      end
   endtask

`ifdef RUN_STATS_EN
   task automatic test_stats();
      for (int t = 0; t < 3; t++) begin
         fill_zero();
         xs[t] = 1'b1;
         run_trial($sformatf("stats_hit%0d", t), 1, t, 1'b0, 1'b0);
      end
      fill_zero();
      run_trial("stats_miss", 3, 0, 1'b0, 1'b0);
      n_checks++;
      if (hit_count !== 16'(exp_hits) || exp_hits != 3) begin
         n_fail++;
         $display("FAIL hit_count: got %0d, expected %0d (3 accepted hits)", hit_count, exp_hits);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_directed();
      test_hold_ready();
      test_back_to_back();
      test_random();
      test_abort();
      test_reset_mid_op();
`ifdef RUN_STATS_EN
      test_stats();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
